// File: rtl/riscv_i32_ifetch_prefetch_pkg.sv
// Shared types for the instruction-fetch memory bridge and its neighbours.
package riscv_i32_ifetch_prefetch_pkg;

    // Fetch request as driven by the fetch-debug stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic        sequential;
        logic [2:0]  mode;
        logic        flush;
    } t_ifetch_req;

    // Fetch response returned to the fetch-debug stage.
    typedef struct packed {
        logic        valid;
        logic        debug;
        logic [31:0] data;
        logic [2:0]  mode;
        logic        error;
        logic [1:0]  tag;
    } t_ifetch_resp;

    // Read request towards the instruction SRAM/bus.
    typedef struct packed {
        logic        valid;
        logic [31:0] address;
    } t_ifetch_mem_req;

    // Read data from the instruction SRAM/bus.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        error;
    } t_ifetch_mem_resp;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DEMAND,
        PREFETCH
    } t_pf_state;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // True when the next sequential word stays inside the same 2^log2-byte region.
    // A 32-bit wrap changes the upper bits, so it is rejected as well.
    function automatic logic same_region(input logic [31:0] addr, input int log2);
        logic [31:0] nxt;
        nxt = addr + WORD_BYTES;
        return (nxt >> log2) == (addr >> log2);
    endfunction

endpackage

// File: rtl/riscv_i32_ifetch_prefetch.sv
// Instruction-fetch memory bridge: single-outstanding memory reads plus a
// one-word sequential prefetch buffer that lets the next sequential fetch
// complete without touching memory.
module riscv_i32_ifetch_prefetch
    import riscv_i32_ifetch_prefetch_pkg::*;
#(
    parameter int PF_BOUNDARY_LOG2 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifetch_req__valid,
    input  logic [31:0] ifetch_req__address,
    input  logic        ifetch_req__sequential,
    input  logic [2:0]  ifetch_req__mode,
    input  logic        ifetch_req__flush,
    output logic        ifetch_resp__valid,
    output logic        ifetch_resp__debug,
    output logic [31:0] ifetch_resp__data,
    output logic [2:0]  ifetch_resp__mode,
    output logic        ifetch_resp__error,
    output logic [1:0]  ifetch_resp__tag,
    output logic        mem_req__valid,
    output logic [31:0] mem_req__address,
    input  logic        mem_req_ack,
    input  logic        mem_resp__valid,
    input  logic [31:0] mem_resp__data,
    input  logic        mem_resp__error
);

    t_pf_state       state;
    t_ifetch_resp    resp_q;
    t_ifetch_mem_req mreq_q;

    // Prefetch buffer: pf_addr/pf_mode also track the in-flight prefetch.
    logic        pf_valid;
    logic [31:0] pf_addr;
    logic [31:0] pf_data;
    logic        pf_error;
    logic [2:0]  pf_mode;

    logic        discard;
    logic        outstanding;
    logic [1:0]  tag_cnt;
    logic [31:0] dmd_addr;
    logic [2:0]  dmd_mode;

    // The sequential hint is redundant with the address compare.
    logic unused_sequential;
    assign unused_sequential = ifetch_req__sequential;

    logic accept;
    logic misaligned;
    logic pf_hit;
    logic pf_req_match;
    logic pf_drop;

    assign accept       = (state == IDLE) && ifetch_req__valid;
    assign misaligned   = |ifetch_req__address[1:0];
    assign pf_hit       = pf_valid && !ifetch_req__flush &&
                          (pf_addr == ifetch_req__address) && (pf_mode == ifetch_req__mode);
    // A held request that wants exactly the word currently being prefetched.
    assign pf_req_match = ifetch_req__valid && !ifetch_req__flush &&
                          (pf_addr == ifetch_req__address) && (pf_mode == ifetch_req__mode);
    // Returning prefetch data is useless if someone asked for something else.
    assign pf_drop      = discard || (ifetch_req__valid && !pf_req_match);

    // Request acceptance, memory sequencing and prefetch buffer maintenance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            resp_q      <= '0;
            mreq_q      <= '0;
            pf_valid    <= 1'b0;
            pf_addr     <= '0;
            pf_data     <= '0;
            pf_error    <= 1'b0;
            pf_mode     <= '0;
            discard     <= 1'b0;
            outstanding <= 1'b0;
            tag_cnt     <= '0;
            dmd_addr    <= '0;
            dmd_mode    <= '0;
        end else begin
            resp_q <= '0;
            if (mreq_q.valid && mem_req_ack) begin
                mreq_q.valid <= 1'b0;
                outstanding  <= 1'b1;
            end
            if (mem_resp__valid) begin
                outstanding <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ifetch_req__valid) begin
                        if (ifetch_req__flush) begin
                            pf_valid <= 1'b0;
                        end
                        if (misaligned) begin
                            resp_q  <= '{valid: 1'b1, debug: 1'b0, data: 32'h0,
                                         mode: ifetch_req__mode, error: 1'b1, tag: tag_cnt};
                            tag_cnt <= tag_cnt + 2'd1;
                        end else if (pf_hit) begin
                            resp_q   <= '{valid: 1'b1, debug: 1'b0, data: pf_data,
                                          mode: ifetch_req__mode, error: pf_error, tag: tag_cnt};
                            tag_cnt  <= tag_cnt + 2'd1;
                            pf_valid <= 1'b0;
                            if (!pf_error && same_region(ifetch_req__address, PF_BOUNDARY_LOG2)) begin
                                mreq_q  <= '{valid: 1'b1, address: ifetch_req__address + WORD_BYTES};
                                pf_addr <= ifetch_req__address + WORD_BYTES;
                                pf_mode <= ifetch_req__mode;
                                state   <= PREFETCH;
                            end
                        end else begin
                            mreq_q   <= '{valid: 1'b1, address: ifetch_req__address};
                            dmd_addr <= ifetch_req__address;
                            dmd_mode <= ifetch_req__mode;
                            state    <= WAIT_DEMAND;
                        end
                    end
                end

                WAIT_DEMAND: begin
                    if (mem_resp__valid) begin
                        resp_q  <= '{valid: 1'b1, debug: 1'b0, data: mem_resp__data,
                                     mode: dmd_mode, error: mem_resp__error, tag: tag_cnt};
                        tag_cnt <= tag_cnt + 2'd1;
                        if (!mem_resp__error && same_region(dmd_addr, PF_BOUNDARY_LOG2)) begin
                            mreq_q  <= '{valid: 1'b1, address: dmd_addr + WORD_BYTES};
                            pf_addr <= dmd_addr + WORD_BYTES;
                            pf_mode <= dmd_mode;
                            state   <= PREFETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                PREFETCH: begin
                    if (ifetch_req__valid && !pf_req_match) begin
                        discard <= 1'b1;
                    end
                    if (mem_resp__valid) begin
                        discard <= 1'b0;
                        if (pf_drop) begin
                            // Held demand is re-examined from IDLE next cycle.
                            pf_valid <= 1'b0;
                            state    <= IDLE;
                        end else if (pf_req_match) begin
                            // Forward straight to the waiting fetch and keep streaming.
                            resp_q  <= '{valid: 1'b1, debug: 1'b0, data: mem_resp__data,
                                         mode: pf_mode, error: mem_resp__error, tag: tag_cnt};
                            tag_cnt <= tag_cnt + 2'd1;
                            if (!mem_resp__error && same_region(pf_addr, PF_BOUNDARY_LOG2)) begin
                                mreq_q  <= '{valid: 1'b1, address: pf_addr + WORD_BYTES};
                                pf_addr <= pf_addr + WORD_BYTES;
                                state   <= PREFETCH;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            pf_valid <= 1'b1;
                            pf_data  <= mem_resp__data;
                            pf_error <= mem_resp__error;
                            state    <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign ifetch_resp__valid = resp_q.valid;
    assign ifetch_resp__debug = resp_q.debug;
    assign ifetch_resp__data  = resp_q.data;
    assign ifetch_resp__mode  = resp_q.mode;
    assign ifetch_resp__error = resp_q.error;
    assign ifetch_resp__tag   = resp_q.tag;
    assign mem_req__valid     = mreq_q.valid;
    assign mem_req__address   = mreq_q.address;

    // Memory must only answer what was asked; responses never stack without a fresh accept.
    a_resp_owed: assert property (@(posedge clk) disable iff (reset)
        mem_resp__valid |-> (outstanding || (mreq_q.valid && mem_req_ack)));
    a_resp_pulse: assert property (@(posedge clk) disable iff (reset)
        (ifetch_resp__valid && !accept) |=> !ifetch_resp__valid);

endmodule
